song_reader: RTL and testbench

Sequencer that reads the song ROM and drives the note player. For the selected song (one 32-entry segment of the 128-entry ROM) it fetches each `{note, duration}` word in order. It presents each note for exactly `duration` beat ticks, then signals completion at the end of the segment. It sits between the user controls (play/song select), the song ROM, and the note player.

---
 rtl/song_reader.sv | 129 ++++++++++++
 tb/tb_song_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song sequencer: walks one 32-entry segment of the song ROM and presents
// each {note, duration} entry to the note player for `duration` beat ticks.
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      play,
    input  logic [1:0]                song,
    input  logic                      beat,
    output logic [IDX_W+1:0]          rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_dout,
    output logic [NOTE_W-1:0]         note_to_play,
    output logic                      new_note,
    output logic                      playing,
    output logic                      song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          song_q, song_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic                new_note_q, new_note_d;
    logic                song_done_q, song_done_d;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic [DUR_W-1:0]    cnt_inc;

    assign rom_note = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_dout[DUR_W-1:0];
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            song_q      <= '0;
            idx_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            cnt_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            cnt_q       <= cnt_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        idx_d       = idx_q;
        note_d      = note_q;
        dur_d       = dur_q;
        cnt_d       = cnt_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                note_d = '0;
                if (play) begin
                    song_d  = song;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            // The ROM is registered: rom_dout reflects rom_addr one edge later.
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_dur != '0) begin
                    note_d     = rom_note;
                    dur_d      = rom_dur;
                    cnt_d      = '0;
                    new_note_d = 1'b1;
                    state_d    = S_PLAY;
                end else begin
                    state_d    = S_NEXT;
                end
            end
            S_PLAY: begin
                // Pausing simply gates the beat, so the count resumes intact.
                if (play && beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == dur_q) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (idx_q == '1) begin
                    song_done_d = 1'b1;
                    note_d      = '0;
                    state_d     = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr     = {song_q, idx_q};
    assign note_to_play = note_q;
    assign new_note     = new_note_q;
    assign song_done    = song_done_q;
    assign playing      = (state_q == S_PLAY) && play;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a registered 128x12 song ROM model.
module tb_song_reader;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [11:0] rom_dout;
    logic [5:0]  note_to_play;
    logic        new_note;
    logic        playing;
    logic        song_done;

    logic [11:0] rom [0:127];
    int checks;
    int errors;
    int overlap;

    song_reader #(
        .NOTE_W(6),
        .DUR_W (6),
        .IDX_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .play        (play),
        .song        (song),
        .beat        (beat),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .note_to_play(note_to_play),
        .new_note    (new_note),
        .playing     (playing),
        .song_done   (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    always @(negedge clk) if (new_note && song_done) overlap++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One beat high across exactly one edge, followed by a quiet cycle.
    task automatic give_beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
            tick();
        end
    endtask

    task automatic give_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic wait_addr(input logic [6:0] target, input int budget);
        int n;
        n = 0;
        while (rom_addr != target && n < budget) begin
            beat = ~beat;
            tick();
            n++;
        end
        beat = 1'b0;
        chk("reach_addr", 32'(rom_addr), 32'(target));
    endtask

    initial begin
        int out_of_range;
        int n;
        checks  = 0;
        errors  = 0;
        overlap = 0;
        for (int i = 0; i < 128; i++) begin
            rom[i] = {6'((i % 61) + 1), 6'd1};
        end
        rom[32]  = {6'd35, 6'd36};
        rom[33]  = {6'd42, 6'd36};
        rom[28]  = {6'd37, 6'd0};
        rom[29]  = {6'd5,  6'd1};
        rom[30]  = {6'd0,  6'd0};
        rom[31]  = {6'd0,  6'd2};
        rom[127] = {6'd37, 6'd1};

        rst_n = 1'b0;
        play  = 1'b0;
        song  = 2'd0;
        beat  = 1'b0;
        tick();
        tick();
        chk("rst_addr",     32'(rom_addr), 0);
        chk("rst_note",     32'(note_to_play), 0);
        chk("rst_new_note", 32'(new_note), 0);
        chk("rst_playing",  32'(playing), 0);
        chk("rst_done",     32'(song_done), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_hold_addr", 32'(rom_addr), 0);

        // Start song 1: new_note appears after the third edge.
        song = 2'd1;
        play = 1'b1;
        tick();
        chk("start_addr", 32'(rom_addr), 32);
        chk("start_nn0",  32'(new_note), 0);
        tick();
        chk("start_nn1",  32'(new_note), 0);
        tick();
        chk("start_nn2",  32'(new_note), 1);
        chk("start_note", 32'(note_to_play), 35);
        chk("start_play", 32'(playing), 1);
        tick();
        chk("start_pulse_len", 32'(new_note), 0);
        give_beats(35);
        chk("n0_35_play", 32'(playing), 1);
        chk("n0_35_note", 32'(note_to_play), 35);
        chk("n0_35_addr", 32'(rom_addr), 32);
        give_beat();
        chk("n0_end_play", 32'(playing), 0);
        tick();
        chk("n1_addr", 32'(rom_addr), 33);
        tick();
        tick();
        chk("n1_nn",   32'(new_note), 1);
        chk("n1_note", 32'(note_to_play), 42);

        // Pause after 10 of 36 beats; 20 beats during pause are ignored.
        give_beats(10);
        play = 1'b0;
        tick();
        chk("pause_playing", 32'(playing), 0);
        give_beats(20);
        chk("pause_playing2", 32'(playing), 0);
        chk("pause_note",     32'(note_to_play), 42);
        chk("pause_addr",     32'(rom_addr), 33);
        play = 1'b1;
        tick();
        chk("resume_playing", 32'(playing), 1);
        give_beats(25);
        chk("resume_25_playing", 32'(playing), 1);
        chk("resume_25_note",    32'(note_to_play), 42);
        give_beat();
        chk("resume_26_end", 32'(playing), 0);
        tick();
        chk("n2_addr", 32'(rom_addr), 34);

        // Song select changed mid-song is ignored until the next IDLE.
        song = 2'd2;
        out_of_range = 0;
        n = 0;
        while (!song_done && n < 800) begin
            beat = ~beat;
            tick();
            if (rom_addr < 7'd32 || rom_addr > 7'd63) out_of_range++;
            n++;
        end
        beat = 1'b0;
        chk("s1_done_seen",    32'(song_done), 1);
        chk("s1_addr_range",   32'(out_of_range), 0);
        chk("s1_done_note",    32'(note_to_play), 0);
        tick();
        chk("s2_start_addr",   32'(rom_addr), 64);
        chk("s1_done_pulse",   32'(song_done), 0);
        tick();
        tick();
        chk("s2_nn",      32'(new_note), 1);
        chk("s2_playing", 32'(playing), 1);

        // Asynchronous reset mid-note.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr",    32'(rom_addr), 0);
        chk("arst_note",    32'(note_to_play), 0);
        chk("arst_nn",      32'(new_note), 0);
        chk("arst_playing", 32'(playing), 0);
        chk("arst_done",    32'(song_done), 0);
        tick();
        chk("arst_hold_done", 32'(song_done), 0);
        song = 2'd0;
        rst_n = 1'b1;

        // Song 0: entries 28 and 30 have zero duration and are skipped.
        wait_addr(7'd28, 400);
        tick();
        chk("skip28_nn_a", 32'(new_note), 0);
        tick();
        chk("skip28_nn_b",  32'(new_note), 0);
        chk("skip28_note",  32'(note_to_play), 28);
        tick();
        chk("addr29", 32'(rom_addr), 29);
        tick();
        tick();
        chk("n29_nn",   32'(new_note), 1);
        chk("n29_note", 32'(note_to_play), 5);
        give_beat();
        tick();
        chk("addr30", 32'(rom_addr), 30);
        tick();
        tick();
        chk("skip30_nn",   32'(new_note), 0);
        chk("skip30_note", 32'(note_to_play), 5);
        tick();
        chk("addr31", 32'(rom_addr), 31);
        tick();
        tick();
        chk("rest_nn",      32'(new_note), 1);
        chk("rest_note",    32'(note_to_play), 0);
        chk("rest_playing", 32'(playing), 1);
        tick();
        give_beat();
        tick();
        chk("rest_1beat_playing", 32'(playing), 1);
        give_beat();
        chk("rest_end_done", 32'(song_done), 0);
        tick();
        chk("s0_done",    32'(song_done), 1);
        chk("s0_done_nn", 32'(new_note), 0);
        tick();
        chk("s0_restart_addr", 32'(rom_addr), 0);
        chk("s0_done_len",     32'(song_done), 0);

        // End of song 3 with play held high restarts at entry 96.
        rst_n = 1'b0;
        song  = 2'd3;
        tick();
        rst_n = 1'b1;
        wait_addr(7'd127, 1000);
        tick();
        tick();
        chk("n127_nn",   32'(new_note), 1);
        chk("n127_note", 32'(note_to_play), 37);
        give_beat();
        chk("n127_end_done", 32'(song_done), 0);
        tick();
        chk("s3_done",      32'(song_done), 1);
        chk("s3_done_note", 32'(note_to_play), 0);
        tick();
        chk("s3_restart_addr", 32'(rom_addr), 96);
        chk("s3_done_len",     32'(song_done), 0);

        chk("nn_done_overlap", 32'(overlap), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
